// File: rtl/cam_frame_stats.sv
// DVP camera capture: synchronises the camera bus into clk, assembles RGB565/RGB332
// pixels and publishes per-frame total and green pixel counts with saturation reporting.
module cam_frame_stats #(
  parameter int PIX_MODE = 0,
  parameter int CNT_W    = 16,
  parameter int G_MIN    = 16,
  parameter int MARGIN   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cam_vsync,
  input  logic             cam_href,
  input  logic             cam_pclk,
  input  logic [7:0]       cam_data,
  output logic [CNT_W-1:0] pixel_count,
  output logic [CNT_W-1:0] green_count,
  output logic             stats_valid,
  output logic             frame_overflow,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, FRAME, PUBLISH} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [6:0]       G_MIN7  = 7'(G_MIN);
  localparam logic [6:0]       MARGIN7 = 7'(MARGIN);

  state_t           state, state_nxt;
  logic [2:0]       vsync_s, href_s, pclk_s;
  logic [7:0]       data_d0, data_d1;
  logic             vsync_rise, vsync_fall, href_rise, pclk_rise;
  logic             byte_stb, phase, phase_cur, pix_done, is_green;
  logic [7:0]       hi_byte;
  logic [5:0]       r6, g6, b6;
  logic [CNT_W-1:0] pix_cnt, grn_cnt;
  logic             ovf;

  // Stages [1:0] synchronise, stage [2] is the edge-detect delay. Data runs two
  // stages so the byte in data_d1 is the one present when pclk_s[0] saw the rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_s <= '0;
      href_s  <= '0;
      pclk_s  <= '0;
      data_d0 <= '0;
      data_d1 <= '0;
    end else begin
      vsync_s <= {vsync_s[1:0], cam_vsync};
      href_s  <= {href_s[1:0], cam_href};
      pclk_s  <= {pclk_s[1:0], cam_pclk};
      data_d0 <= cam_data;
      data_d1 <= data_d0;
    end
  end

  assign vsync_rise = vsync_s[1] & ~vsync_s[2];
  assign vsync_fall = ~vsync_s[1] & vsync_s[2];
  assign href_rise  = href_s[1] & ~href_s[2];
  assign pclk_rise  = pclk_s[1] & ~pclk_s[2];
  assign byte_stb   = (state == FRAME) && href_s[1] && pclk_rise;
  assign phase_cur  = href_rise ? 1'b0 : phase;

  // Pixel assembly and 6-bit normalisation.
  always_comb begin
    pix_done = 1'b0;
    r6       = '0;
    g6       = '0;
    b6       = '0;
    if (PIX_MODE == 0) begin
      pix_done = byte_stb && phase_cur;
      r6       = {hi_byte[7:3], hi_byte[7]};
      g6       = {hi_byte[2:0], data_d1[7:5]};
      b6       = {data_d1[4:0], data_d1[4]};
    end else begin
      pix_done = byte_stb;
      r6       = {data_d1[7:5], data_d1[7:5]};
      g6       = {data_d1[4:2], data_d1[4:2]};
      b6       = {3{data_d1[1:0]}};
    end
  end

  // 7-bit compare so r6 + MARGIN cannot wrap.
  assign is_green = ({1'b0, g6} >= G_MIN7) &&
                    ({1'b0, g6} >= ({1'b0, r6} + MARGIN7)) &&
                    ({1'b0, g6} >= ({1'b0, b6} + MARGIN7));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (vsync_fall && enable) state_nxt = FRAME;
      FRAME:   if (vsync_rise) state_nxt = PUBLISH;
      PUBLISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Working counters; a pixel completing alongside the vsync rise still lands here
  // before PUBLISH copies them out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= 1'b0;
      hi_byte <= '0;
      pix_cnt <= '0;
      grn_cnt <= '0;
      ovf     <= 1'b0;
    end else if (state == IDLE && vsync_fall && enable) begin
      phase   <= 1'b0;
      pix_cnt <= '0;
      grn_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      if (byte_stb) begin
        phase <= ~phase_cur;
        if (!phase_cur) hi_byte <= data_d1;
      end else if (href_rise) begin
        phase <= 1'b0;
      end
      if (pix_done) begin
        if (pix_cnt == CNT_MAX) ovf <= 1'b1;
        else                    pix_cnt <= pix_cnt + 1'b1;
        if (is_green) begin
          if (grn_cnt == CNT_MAX) ovf <= 1'b1;
          else                    grn_cnt <= grn_cnt + 1'b1;
        end
      end
    end
  end

  // stats_valid pulses for one cycle together with the newly published counts;
  // there is no backpressure, consumers must take the values on that cycle or later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_count    <= '0;
      green_count    <= '0;
      frame_overflow <= 1'b0;
      stats_valid    <= 1'b0;
    end else begin
      stats_valid <= (state == PUBLISH);
      if (state == PUBLISH) begin
        pixel_count    <= pix_cnt;
        green_count    <= grn_cnt;
        frame_overflow <= ovf;
      end
    end
  end

  assign busy = (state == FRAME);

endmodule

// File: tb/tb_cam_frame_stats.sv
// Bench for cam_frame_stats: three instances (RGB565/16-bit, RGB332/16-bit, RGB565/4-bit)
// share one camera bus and are each checked against an arithmetic pixel model.
module tb_cam_frame_stats;
  localparam int G_MIN  = 16;
  localparam int MARGIN = 8;
  localparam int W      = 33;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic cam_vsync = 1'b1;
  logic cam_href = 1'b0;
  logic cam_pclk = 1'b0;
  logic [7:0] cam_data = 8'h00;

  logic [15:0] pc0, gc0, pc1, gc1;
  logic [3:0]  pc2, gc2;
  logic        sv0, sv1, sv2, ov0, ov1, ov2, bz0, bz1, bz2;

  cam_frame_stats #(.PIX_MODE(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_pclk(cam_pclk), .cam_data(cam_data), .pixel_count(pc0), .green_count(gc0),
    .stats_valid(sv0), .frame_overflow(ov0), .busy(bz0));
  cam_frame_stats #(.PIX_MODE(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_pclk(cam_pclk), .cam_data(cam_data), .pixel_count(pc1), .green_count(gc1),
    .stats_valid(sv1), .frame_overflow(ov1), .busy(bz1));
  cam_frame_stats #(.PIX_MODE(0), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_pclk(cam_pclk), .cam_data(cam_data), .pixel_count(pc2), .green_count(gc2),
    .stats_valid(sv2), .frame_overflow(ov2), .busy(bz2));

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int tot_sv[3];
  int base_sv[3];
  int raw_pix[3];
  int raw_grn[3];
  bit frame_en;
  logic [7:0] line_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] hold_exp[3];

  initial begin
    for (int i = 0; i < 3; i++) tot_sv[i] = 0;
  end

  always @(negedge clk) begin
    if (sv0) tot_sv[0]++;
    if (sv1) tot_sv[1]++;
    if (sv2) tot_sv[2]++;
  end

  function automatic logic [31:0] get_pc(int i);
    case (i)
      0:       return 32'(pc0);
      1:       return 32'(pc1);
      default: return 32'(pc2);
    endcase
  endfunction

  function automatic logic [31:0] get_gc(int i);
    case (i)
      0:       return 32'(gc0);
      1:       return 32'(gc1);
      default: return 32'(gc2);
    endcase
  endfunction

  function automatic logic [31:0] get_flag(int i, bit busy_sel);
    case (i)
      0:       return busy_sel ? 32'(bz0) : 32'(ov0);
      1:       return busy_sel ? 32'(bz1) : 32'(ov1);
      default: return busy_sel ? 32'(bz2) : 32'(ov2);
    endcase
  endfunction

  // reference model: plain arithmetic on colour components
  function automatic bit green6(int r6, int g6, int b6);
    return (g6 >= G_MIN) && (g6 >= r6 + MARGIN) && (g6 >= b6 + MARGIN);
  endfunction

  function automatic bit green565(int hi, int lo);
    int w, r5, b5;
    w  = hi * 256 + lo;
    r5 = w / 2048;
    b5 = w % 32;
    return green6(r5 * 2 + r5 / 16, (w / 32) % 64, b5 * 2 + b5 / 16);
  endfunction

  function automatic bit green332(int b);
    return green6((b / 32) * 9, ((b / 4) % 8) * 9, (b % 4) * 21);
  endfunction

  function automatic int max_of(int i);
    return (i == 2) ? 15 : 65535;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam_data = b;
    wait_clk(2);
    cam_pclk = 1'b1;
    wait_clk(3);
    cam_pclk = 1'b0;
    wait_clk(1);
  endtask

  task automatic send_line();
    cam_href = 1'b1;
    wait_clk(3);
    foreach (line_q[k]) send_byte(line_q[k]);
    wait_clk(4);
    cam_href = 1'b0;
    wait_clk(4);
    if (frame_en) begin
      for (int k = 0; k < line_q.size(); k++) begin
        raw_pix[1]++;
        if (green332(line_q[k])) raw_grn[1]++;
      end
      for (int k = 0; k + 1 < line_q.size(); k += 2) begin
        for (int i = 0; i < 3; i += 2) begin
          raw_pix[i]++;
          if (green565(line_q[k], line_q[k+1])) raw_grn[i]++;
        end
      end
    end
  endtask

  task automatic start_frame();
    for (int i = 0; i < 3; i++) begin
      base_sv[i] = tot_sv[i];
      raw_pix[i] = 0;
      raw_grn[i] = 0;
    end
    frame_en = enable;
    cam_vsync = 1'b0;
    wait_clk(5);
    for (int i = 0; i < 3; i++) chk($sformatf("busy%0d", i), get_flag(i, 1'b1), 32'(frame_en));
  endtask

  task automatic end_frame(input string tag);
    logic [W-1:0] e;
    cam_vsync = 1'b1;
    wait_clk(8);
    if (frame_en) begin
      for (int i = 0; i < 3; i++) begin
        e[32]    = (raw_pix[i] > max_of(i)) || (raw_grn[i] > max_of(i));
        e[31:16] = 16'((raw_grn[i] > max_of(i)) ? max_of(i) : raw_grn[i]);
        e[15:0]  = 16'((raw_pix[i] > max_of(i)) ? max_of(i) : raw_pix[i]);
        exp_q.push_back(e);
      end
      for (int i = 0; i < 3; i++) hold_exp[i] = exp_q.pop_front();
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_pulses%0d", tag, i), 32'(tot_sv[i] - base_sv[i]), 32'(frame_en));
      chk($sformatf("%s_pix%0d", tag, i), get_pc(i), 32'(hold_exp[i][15:0]));
      chk($sformatf("%s_grn%0d", tag, i), get_gc(i), 32'(hold_exp[i][31:16]));
      chk($sformatf("%s_ovf%0d", tag, i), get_flag(i, 1'b0), 32'(hold_exp[i][32]));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_pix%0d", tag, i), get_pc(i), 32'd0);
      chk($sformatf("%s_grn%0d", tag, i), get_gc(i), 32'd0);
      chk($sformatf("%s_ovf%0d", tag, i), get_flag(i, 1'b0), 32'd0);
      chk($sformatf("%s_busy%0d", tag, i), get_flag(i, 1'b1), 32'd0);
    end
    chk({tag, "_sv0"}, 32'(sv0), 32'd0);
  endtask

  initial begin
    logic [7:0] pick[5];
    pick[0] = 8'h3C; pick[1] = 8'hA0; pick[2] = 8'h1C; pick[3] = 8'hF8; pick[4] = 8'hE0;
    for (int i = 0; i < 3; i++) hold_exp[i] = '0;

    wait_clk(4);
    check_zero("reset");
    rst_n = 1'b1;
    enable = 1'b1;
    wait_clk(6);

    // basic RGB565 frame
    start_frame();
    for (int l = 0; l < 10; l++) begin
      line_q = '{8'h3C, 8'hA0};
      send_line();
    end
    end_frame("basic");

    // mixed green / red pixels
    start_frame();
    for (int l = 0; l < 5; l++) begin
      line_q = '{8'h3C, 8'hA0, 8'hF8, 8'h00};
      send_line();
    end
    end_frame("mixed");

    // odd trailing byte
    start_frame();
    line_q = '{8'h3C, 8'hA0, 8'h3C};
    send_line();
    end_frame("odd");

    // frame started with enable low: nothing published, outputs hold
    enable = 1'b0;
    start_frame();
    line_q = '{8'h3C, 8'hA0, 8'h3C, 8'hA0};
    send_line();
    enable = 1'b1;
    end_frame("gated");

    // RGB332 directed colours
    start_frame();
    line_q = '{8'h1C, 8'hE0, 8'hFF};
    send_line();
    end_frame("rgb332");

    // saturation of the 4-bit instance, then recovery
    start_frame();
    for (int l = 0; l < 4; l++) begin
      line_q = '{8'h3C, 8'hA0, 8'h3C, 8'hA0, 8'h3C, 8'hA0, 8'h3C, 8'hA0, 8'h3C, 8'hA0};
      send_line();
    end
    end_frame("sat");
    start_frame();
    line_q = '{8'h3C, 8'hA0, 8'h3C, 8'hA0};
    send_line();
    end_frame("unsat");

    // randomized frames
    for (int f = 0; f < 4; f++) begin
      enable = ($urandom_range(0, 3) != 0);
      start_frame();
      for (int l = 0; l < int'($urandom_range(1, 4)); l++) begin
        line_q = {};
        for (int k = 0; k < int'($urandom_range(0, 7)); k++)
          line_q.push_back(($urandom_range(0, 2) == 0) ? 8'($urandom) : pick[$urandom_range(0, 4)]);
        send_line();
      end
      end_frame($sformatf("rand%0d", f));
    end
    enable = 1'b1;

    // reset in the middle of line 3
    start_frame();
    for (int l = 0; l < 2; l++) begin
      line_q = '{8'h3C, 8'hA0};
      send_line();
    end
    cam_href = 1'b1;
    wait_clk(3);
    send_byte(8'h3C);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    for (int i = 0; i < 3; i++) hold_exp[i] = '0;
    frame_en = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    send_byte(8'hA0);
    wait_clk(4);
    cam_href = 1'b0;
    wait_clk(4);
    end_frame("after_rst");

    // full frame after the reset
    start_frame();
    for (int l = 0; l < 3; l++) begin
      line_q = '{8'h3C, 8'hA0, 8'h1C, 8'hE0};
      send_line();
    end
    end_frame("recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
